// File: rtl/rng_stream_pkg.sv
// rng_stream_pkg: command bytes and serializer state encoding for rng_byte_streamer
package rng_stream_pkg;
    localparam logic [7:0] CMD_RESET = 8'h72;
    localparam logic [7:0] CMD_PAUSE = 8'h70;
    localparam logic [7:0] CMD_RUN   = 8'h67;
    localparam logic [7:0] CMD_CLR   = 8'h63;
    typedef enum logic [2:0] {IDLE, SYNC, SEND, GAP, WAIT} state_t;
endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: synchronous word FIFO with flush, level and a registered read word
module rng_word_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            level  <= level + LW'(do_push) - LW'(do_pop);
            dout   <= do_pop ? mem[rd_ptr] : dout;
        end
    end
endmodule

// File: rtl/rng_byte_streamer.sv
// rng_byte_streamer: buffers random words and streams them LSB-byte-first to a UART, with command decode
module rng_byte_streamer
    import rng_stream_pkg::*;
#(
    parameter int         WORD_WIDTH   = 16,
    parameter int         DEPTH        = 8,
    parameter int         FRAME_WORDS  = 0,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter bit         RUN_AT_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WORD_WIDTH-1:0]     in_word,
    input  logic                      in_valid,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_received,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_byte,
    output logic                      reset_req,
    output logic                      running,
    output logic                      overflow,
    output logic [$clog2(DEPTH):0]    fill_level
);
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int CW    = $clog2(FRAME_WORDS + 2);
    logic                  cmd_r, cmd_p, cmd_g, cmd_c;
    logic                  full, empty, pop, drop;
    logic [WORD_WIDTH-1:0] rd_word, cur;
    state_t                state, state_n;
    logic [IW-1:0]         idx, idx_n;
    logic                  sync_ret, sync_ret_n;
    logic [CW-1:0]         frame_cnt, frame_n;
    assign cmd_r = rx_received && rx_byte == CMD_RESET;
    assign cmd_p = rx_received && rx_byte == CMD_PAUSE;
    assign cmd_g = rx_received && rx_byte == CMD_RUN;
    assign cmd_c = rx_received && rx_byte == CMD_CLR;
    assign drop  = in_valid && running && full;
    assign cur   = rd_word >> {idx, 3'b000};
    rng_word_fifo #(.W(WORD_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && running),
        .din   (in_word),
        .pop   (pop),
        .flush (cmd_r),
        .dout  (rd_word),
        .full  (full),
        .empty (empty),
        .level (fill_level)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   <= RUN_AT_RESET;
            overflow  <= 1'b0;
            reset_req <= 1'b0;
        end else begin
            reset_req <= cmd_r;
            running   <= cmd_g ? 1'b1 : cmd_p ? 1'b0 : running;
            overflow  <= drop ? 1'b1 : cmd_c ? 1'b0 : overflow;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            sync_ret  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            sync_ret  <= sync_ret_n;
            frame_cnt <= frame_n;
        end
    end
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        sync_ret_n = sync_ret;
        frame_n    = frame_cnt;
        pop        = 1'b0;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        unique case (state)
            IDLE: if (!empty) begin
                pop        = 1'b1;
                idx_n      = '0;
                sync_ret_n = 1'b0;
                state_n    = (FRAME_WORDS != 0 && frame_cnt == '0) ? SYNC : SEND;
            end
            SYNC: begin
                tx_byte = SYNC_BYTE;
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    sync_ret_n = 1'b1;
                    state_n    = GAP;
                end
            end
            SEND: begin
                tx_byte = cur[7:0];
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_n  = GAP;
                end
            end
            GAP: state_n = WAIT;
            WAIT: if (!tx_busy) begin
                if (sync_ret) begin
                    sync_ret_n = 1'b0;
                    state_n    = SEND;
                end else if (idx != IW'(BYTES - 1)) begin
                    idx_n   = idx + IW'(1);
                    state_n = SEND;
                end else begin
                    frame_n = (frame_cnt == CW'(FRAME_WORDS - 1)) ? '0 : frame_cnt + CW'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (cmd_r) begin
            state_n    = IDLE;
            idx_n      = '0;
            sync_ret_n = 1'b0;
            frame_n    = '0;
            pop        = 1'b0;
        end
    end
endmodule
